// File: rtl/bus_snooper.sv
// Two-block MSI snooper. It watches bus messages, downgrades or invalidates
// the local copies and writes back dirty data before the snooped miss completes.
module bus_snooper #(
  parameter int WB_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bus_valid,
  input  logic [1:0] bus_op,
  input  logic [2:0] bus_address,
  output logic       bus_ready,
  input  logic       fill_en,
  input  logic [1:0] fill_state,
  input  logic [2:0] fill_address,
  input  logic [3:0] fill_data,
  output logic       fill_ready,
  output logic       write_back,
  output logic [2:0] wb_address,
  output logic [3:0] wb_data,
  input  logic       mem_ack,
  output logic       abort_access,
  output logic [1:0] state_cb0,
  output logic [1:0] state_cb1,
  output logic       wb_timeout,
  output logic [1:0] dbg_state
);

  // Handshakes: a bus message transfers on a clock edge where bus_valid and
  // bus_ready are both 1; a fill transfers where fill_en and fill_ready are
  // both 1; the write-back transfers where write_back and mem_ack are both 1.
  // A fill without fill_ready is dropped rather than held.

  localparam logic [1:0] MSI_I = 2'b00;
  localparam logic [1:0] MSI_S = 2'b01;
  localparam logic [1:0] MSI_M = 2'b10;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;

  localparam logic [3:0] WB_LAST = 4'(WB_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WB     = 2'd2
  } fsm_t;

  fsm_t state, state_next;

  logic [1:0][1:0] blk_state;
  logic [1:0][2:0] blk_tag;
  logic [1:0][3:0] blk_data;

  logic [1:0] cap_op;
  logic [2:0] cap_addr;
  logic [3:0] wb_cnt, wb_cnt_next;
  logic       timeout_next;

  logic       upd_en;
  logic [1:0] upd_state;

  logic       idx;
  logic [1:0] cur_state;
  logic       hit;

  assign idx       = cap_addr[0];
  assign cur_state = blk_state[idx];
  assign hit       = (blk_tag[idx] == cap_addr) && (cur_state != MSI_I);

  assign bus_ready    = (state == S_IDLE);
  assign fill_ready   = (state == S_IDLE) && !bus_valid;
  assign write_back   = (state == S_WB);
  assign abort_access = (state == S_WB);
  assign wb_address   = write_back ? blk_tag[idx]  : 3'd0;
  assign wb_data      = write_back ? blk_data[idx] : 4'd0;
  assign state_cb0    = blk_state[0];
  assign state_cb1    = blk_state[1];
  assign dbg_state    = state;

  always_comb begin
    state_next   = state;
    wb_cnt_next  = wb_cnt;
    timeout_next = 1'b0;
    upd_en       = 1'b0;
    upd_state    = cur_state;
    case (state)
      S_IDLE: begin
        if (bus_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_next  = S_IDLE;
        wb_cnt_next = 4'd0;
        case (cap_op)
          OP_RD: begin
            if (hit && cur_state == MSI_M) state_next = S_WB;
          end
          OP_WR: begin
            if (hit && cur_state == MSI_M) begin
              state_next = S_WB;
            end else if (hit) begin
              upd_en    = 1'b1;
              upd_state = MSI_I;
            end
          end
          OP_INV: begin
            // Invalidate drops dirty data too: the requester owns the line now.
            if (hit) begin
              upd_en    = 1'b1;
              upd_state = MSI_I;
            end
          end
          default: ;
        endcase
      end
      S_WB: begin
        if (mem_ack || wb_cnt == WB_LAST) begin
          state_next   = S_IDLE;
          upd_en       = 1'b1;
          upd_state    = (cap_op == OP_RD) ? MSI_S : MSI_I;
          timeout_next = !mem_ack;
        end else begin
          wb_cnt_next = wb_cnt + 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cap_op     <= 2'd0;
      cap_addr   <= 3'd0;
      wb_cnt     <= 4'd0;
      wb_timeout <= 1'b0;
      blk_state  <= '0;
      blk_tag    <= '0;
      blk_data   <= '0;
    end else begin
      state      <= state_next;
      wb_cnt     <= wb_cnt_next;
      wb_timeout <= timeout_next;
      if (state == S_IDLE && bus_valid) begin
        cap_op   <= bus_op;
        cap_addr <= bus_address;
      end
      if (upd_en) blk_state[idx] <= upd_state;
      if (fill_en && fill_ready) begin
        blk_state[fill_address[0]] <= (fill_state == 2'b11) ? MSI_I : fill_state;
        blk_tag[fill_address[0]]   <= fill_address;
        blk_data[fill_address[0]]  <= fill_data;
      end
    end
  end

endmodule

// File: tb/tb_bus_snooper.sv
// Directed bench for bus_snooper: fills, snoops, write-backs with and
// without mem_ack, fill/snoop collision and reset during write-back.
module tb_bus_snooper;

  logic       clock;
  logic       reset;
  logic       bus_valid;
  logic [1:0] bus_op;
  logic [2:0] bus_address;
  logic       bus_ready;
  logic       fill_en;
  logic [1:0] fill_state;
  logic [2:0] fill_address;
  logic [3:0] fill_data;
  logic       fill_ready;
  logic       write_back;
  logic [2:0] wb_address;
  logic [3:0] wb_data;
  logic       mem_ack;
  logic       abort_access;
  logic [1:0] state_cb0;
  logic [1:0] state_cb1;
  logic       wb_timeout;
  logic [1:0] dbg_state;

  int compared;
  int mismatched;

  bus_snooper #(.WB_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_address(bus_address),
    .bus_ready(bus_ready),
    .fill_en(fill_en), .fill_state(fill_state), .fill_address(fill_address),
    .fill_data(fill_data), .fill_ready(fill_ready),
    .write_back(write_back), .wb_address(wb_address), .wb_data(wb_data),
    .mem_ack(mem_ack), .abort_access(abort_access),
    .state_cb0(state_cb0), .state_cb1(state_cb1),
    .wb_timeout(wb_timeout), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_fill(input logic [1:0] st, input logic [2:0] addr, input logic [3:0] data);
    fill_en = 1'b1; fill_state = st; fill_address = addr; fill_data = data;
    tick();
    fill_en = 1'b0;
  endtask

  task automatic do_snoop(input logic [1:0] op, input logic [2:0] addr);
    bus_valid = 1'b1; bus_op = op; bus_address = addr;
    tick();
    bus_valid = 1'b0;
  endtask

  initial begin
    int hi;
    compared = 0; mismatched = 0;
    reset = 1'b1; bus_valid = 1'b0; bus_op = 2'b00; bus_address = 3'd0;
    fill_en = 1'b0; fill_state = 2'b00; fill_address = 3'd0; fill_data = 4'd0;
    mem_ack = 1'b0;
    tick(); tick();
    chk("rst_bus_ready", {7'd0, bus_ready}, 8'd1);
    chk("rst_write_back", {7'd0, write_back}, 8'd0);
    chk("rst_cb0", {6'd0, state_cb0}, 8'd0);
    chk("rst_cb1", {6'd0, state_cb1}, 8'd0);
    chk("rst_timeout", {7'd0, wb_timeout}, 8'd0);
    chk("rst_fsm", {6'd0, dbg_state}, 8'd0);
    reset = 1'b0;
    tick();

    // Read miss hits dirty block1, ack on second write-back cycle
    chk("fill_ready_idle", {7'd0, fill_ready}, 8'd1);
    do_fill(2'b10, 3'b011, 4'hA);
    chk("fill_m_cb1", {6'd0, state_cb1}, 8'd2);
    do_snoop(2'b00, 3'b011);
    chk("lookup_busy", {7'd0, bus_ready}, 8'd0);
    chk("lookup_fsm", {6'd0, dbg_state}, 8'd1);
    chk("lookup_no_wb", {7'd0, write_back}, 8'd0);
    tick();
    chk("wb1_write_back", {7'd0, write_back}, 8'd1);
    chk("wb1_abort", {7'd0, abort_access}, 8'd1);
    chk("wb1_addr", {5'd0, wb_address}, 8'd3);
    chk("wb1_data", {4'd0, wb_data}, 8'hA);
    tick();
    chk("wb2_write_back", {7'd0, write_back}, 8'd1);
    chk("wb2_data", {4'd0, wb_data}, 8'hA);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rd_done_wb", {7'd0, write_back}, 8'd0);
    chk("rd_done_addr", {5'd0, wb_address}, 8'd0);
    chk("rd_done_cb1", {6'd0, state_cb1}, 8'd1);
    chk("rd_done_ready", {7'd0, bus_ready}, 8'd1);
    chk("rd_done_timeout", {7'd0, wb_timeout}, 8'd0);

    // mem_ack while idle has no effect
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_fsm", {6'd0, dbg_state}, 8'd0);
    chk("idle_ack_wb", {7'd0, write_back}, 8'd0);

    // Write miss hits shared block0
    do_fill(2'b01, 3'b100, 4'h5);
    chk("fill_s_cb0", {6'd0, state_cb0}, 8'd1);
    do_snoop(2'b01, 3'b100);
    chk("wr_s_lookup_wb", {7'd0, write_back}, 8'd0);
    tick();
    chk("wr_s_cb0", {6'd0, state_cb0}, 8'd0);
    chk("wr_s_ready", {7'd0, bus_ready}, 8'd1);
    chk("wr_s_wb", {7'd0, write_back}, 8'd0);

    // Invalidate with tag mismatch
    do_fill(2'b01, 3'b100, 4'h5);
    do_snoop(2'b10, 3'b010);
    tick();
    chk("inv_miss_cb0", {6'd0, state_cb0}, 8'd1);
    chk("inv_miss_wb", {7'd0, write_back}, 8'd0);
    chk("inv_miss_abort", {7'd0, abort_access}, 8'd0);

    // Invalidate hits dirty block0: no write-back
    do_fill(2'b10, 3'b000, 4'h3);
    do_snoop(2'b10, 3'b000);
    chk("inv_m_lookup_wb", {7'd0, write_back}, 8'd0);
    tick();
    chk("inv_m_cb0", {6'd0, state_cb0}, 8'd0);
    chk("inv_m_wb", {7'd0, write_back}, 8'd0);

    // Reserved op leaves a dirty hit alone; fill_state 11 loads I
    do_fill(2'b11, 3'b101, 4'h9);
    chk("fill_11_cb1", {6'd0, state_cb1}, 8'd0);
    do_fill(2'b10, 3'b101, 4'h9);
    do_snoop(2'b11, 3'b101);
    tick();
    chk("rsv_cb1", {6'd0, state_cb1}, 8'd2);
    chk("rsv_wb", {7'd0, write_back}, 8'd0);

    // Write miss on dirty block1 with no ack: timeout
    do_fill(2'b10, 3'b111, 4'hC);
    do_snoop(2'b01, 3'b111);
    tick();
    chk("to_wb_addr", {5'd0, wb_address}, 8'd7);
    chk("to_wb_data", {4'd0, wb_data}, 8'hC);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (write_back !== 1'b1) break;
      hi++;
      tick();
    end
    chk("to_wb_cycles", 8'(hi), 8'd15);
    chk("to_pulse", {7'd0, wb_timeout}, 8'd1);
    chk("to_cb1", {6'd0, state_cb1}, 8'd0);
    chk("to_ready", {7'd0, bus_ready}, 8'd1);
    tick();
    chk("to_pulse_end", {7'd0, wb_timeout}, 8'd0);

    // Snoop and fill in the same idle cycle: fill dropped
    bus_valid = 1'b1; bus_op = 2'b00; bus_address = 3'b000;
    fill_en = 1'b1; fill_state = 2'b10; fill_address = 3'b000; fill_data = 4'hF;
    #1;
    chk("coll_fill_ready", {7'd0, fill_ready}, 8'd0);
    tick();
    bus_valid = 1'b0; fill_en = 1'b0;
    chk("coll_lookup", {6'd0, dbg_state}, 8'd1);
    chk("coll_cb0", {6'd0, state_cb0}, 8'd0);
    tick();
    chk("coll_no_wb", {7'd0, write_back}, 8'd0);
    chk("coll_ready", {7'd0, bus_ready}, 8'd1);

    // Reset in the middle of a write-back
    do_fill(2'b01, 3'b100, 4'h5);
    do_fill(2'b10, 3'b001, 4'h6);
    do_snoop(2'b00, 3'b001);
    tick();
    chk("rwb_active", {7'd0, write_back}, 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rwb_write_back", {7'd0, write_back}, 8'd0);
    chk("rwb_abort", {7'd0, abort_access}, 8'd0);
    chk("rwb_cb0", {6'd0, state_cb0}, 8'd0);
    chk("rwb_cb1", {6'd0, state_cb1}, 8'd0);
    chk("rwb_ready", {7'd0, bus_ready}, 8'd1);
    chk("rwb_fsm", {6'd0, dbg_state}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
